// File: rtl/mmio_pkg.sv
// Shared address map, ctrl bit positions and counter width for the MMIO responder.
package mmio_pkg;

  localparam int CNT_W = 32;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] OFF_CTRL    = 32'h0000_0000;
  localparam logic [31:0] OFF_RX      = 32'h0000_0004;
  localparam logic [31:0] OFF_TX      = 32'h0000_0008;
  localparam logic [31:0] OFF_CYCLE   = 32'h0000_0010;
  localparam logic [31:0] OFF_INSTR   = 32'h0000_0014;
  localparam logic [31:0] OFF_CNT_RST = 32'h0000_0018;

  localparam int CTRL_TX_SPACE = 0;
  localparam int CTRL_RX_VALID = 1;
  localparam int CTRL_TX_OVF   = 2;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Circular byte FIFO for the UART TX path; the caller never pushes when full or pops when empty.
module mmio_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/mmio_io_responder.sv
// MMIO responder for the 0x8000_00xx window: counters, UART RX pop and TX byte path.
// Define MMIO_TX_FIFO_EN for a TX_FIFO_DEPTH-entry TX FIFO; otherwise a single holding register.
module mmio_io_responder #(
  parameter int          TX_FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE     = mmio_pkg::MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        inst_retire,
  output logic [31:0] resp_rdata,
  output logic        resp_hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  import mmio_pkg::*;

  logic             w_ld, w_st;
  logic             w_hit_ctrl, w_hit_rx, w_hit_tx, w_hit_cyc, w_hit_ins, w_hit_crst;
  logic             w_tx_space, w_tx_wr, w_tx_push, w_tx_pop, w_tx_ovf_set, w_cnt_clr;
  logic             w_hit;
  logic [31:0]      w_rdata;
  logic             w_unused;
  logic             r_tx_ovf;
  logic [CNT_W-1:0] r_cyc_cnt, r_instr_cnt;

  // Requests are ignored while reset is asserted, which also keeps rx_ready low.
  assign w_ld = rst & req_valid & ~req_we;
  assign w_st = rst & req_valid &  req_we;

  assign w_hit_ctrl = (req_addr == MMIO_BASE + OFF_CTRL);
  assign w_hit_rx   = (req_addr == MMIO_BASE + OFF_RX);
  assign w_hit_tx   = (req_addr == MMIO_BASE + OFF_TX);
  assign w_hit_cyc  = (req_addr == MMIO_BASE + OFF_CYCLE);
  assign w_hit_ins  = (req_addr == MMIO_BASE + OFF_INSTR);
  assign w_hit_crst = (req_addr == MMIO_BASE + OFF_CNT_RST);

  assign rx_ready     = w_ld & w_hit_rx & rx_valid;
  assign w_tx_wr      = w_st & w_hit_tx;
  assign w_tx_push    = w_tx_wr & w_tx_space;
  assign w_tx_ovf_set = w_tx_wr & ~w_tx_space;
  assign w_tx_pop     = rst & tx_valid & tx_ready;
  assign w_cnt_clr    = w_st & w_hit_crst;

`ifdef MMIO_TX_FIFO_EN
  logic w_full, w_empty;

  mmio_tx_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_wdata (req_wdata[7:0]),
    .i_pop   (w_tx_pop),
    .o_rdata (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_tx_space = ~w_full;
  assign tx_valid   = ~w_empty;
  assign w_unused   = ^req_wdata[31:8];
`else
  logic [7:0] r_tx_data;
  logic       r_tx_full;

  // Push requires space and pop requires a byte, so they never coincide here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_data <= '0;
      r_tx_full <= 1'b0;
    end else if (w_tx_push) begin
      r_tx_data <= req_wdata[7:0];
      r_tx_full <= 1'b1;
    end else if (w_tx_pop) begin
      r_tx_full <= 1'b0;
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_full;
  assign w_tx_space = ~r_tx_full;
  assign w_unused   = ^{req_wdata[31:8], TX_FIFO_DEPTH[0]};
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b0;
    if (w_ld) begin
      if (w_hit_ctrl) begin
        w_hit                  = 1'b1;
        w_rdata[CTRL_TX_SPACE] = w_tx_space;
        w_rdata[CTRL_RX_VALID] = rx_valid;
        w_rdata[CTRL_TX_OVF]   = r_tx_ovf;
      end else if (w_hit_rx) begin
        w_hit = 1'b1;
        if (rx_valid) w_rdata = {24'd0, rx_data};
      end else if (w_hit_cyc) begin
        w_hit   = 1'b1;
        w_rdata = r_cyc_cnt;
      end else if (w_hit_ins) begin
        w_hit   = 1'b1;
        w_rdata = r_instr_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_rdata  <= '0;
      resp_hit    <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_cyc_cnt   <= '0;
      r_instr_cnt <= '0;
    end else begin
      resp_hit <= w_hit;
      if (w_ld) resp_rdata <= w_rdata;
      // A same-cycle overflow beats the read-to-clear.
      if (w_tx_ovf_set)           r_tx_ovf <= 1'b1;
      else if (w_ld & w_hit_ctrl) r_tx_ovf <= 1'b0;
      if (w_cnt_clr) begin
        r_cyc_cnt   <= '0;
        r_instr_cnt <= '0;
      end else begin
        r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
        if (inst_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed self-checking bench for mmio_io_responder; adapts TX capacity to MMIO_TX_FIFO_EN.
module tb_mmio_io_responder;

`ifdef MMIO_TX_FIFO_EN
  localparam int TX_CAP = 8;
`else
  localparam int TX_CAP = 1;
`endif

  localparam logic [31:0] A_CTRL  = 32'h8000_0000;
  localparam logic [31:0] A_RX    = 32'h8000_0004;
  localparam logic [31:0] A_TX    = 32'h8000_0008;
  localparam logic [31:0] A_CYC   = 32'h8000_0010;
  localparam logic [31:0] A_INSTR = 32'h8000_0014;
  localparam logic [31:0] A_CRST  = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, inst_retire;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  int n_pass  = 0;
  int n_total = 0;

  mmio_io_responder #(.TX_FIFO_DEPTH(8), .MMIO_BASE(32'h8000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .inst_retire (inst_retire),
    .resp_rdata  (resp_rdata),
    .resp_hit    (resp_hit),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic        exp_rx_ready;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic load(input logic [31:0] addr);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    req_wdata = '0;
    tick();
    idle();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    tick();
    idle();
  endtask

  initial begin
    int n;
    rst = 1'b0; inst_retire = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = '0;
    idle();
    vecs[0]  = '{1'b0, A_CTRL,        32'h0, 1'b0, 8'h00, 32'h1,  1'b1, 1'b0};
    vecs[1]  = '{1'b0, A_CTRL,        32'h0, 1'b1, 8'h00, 32'h3,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, A_RX,          32'h0, 1'b1, 8'hA5, 32'hA5, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, A_RX,          32'h0, 1'b0, 8'hA5, 32'h0,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0, 1'b1, 8'h77, 32'h0,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0005, 32'h0, 1'b1, 8'h77, 32'h0,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, A_RX,          32'h0, 1'b1, 8'h3C, 32'h3C, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, A_RX,          32'h5A, 1'b1, 8'h11, 32'h3C, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, A_TX,          32'h0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    vecs[9]  = '{1'b0, A_CRST,        32'h0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h8000_000C, 32'h5A, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_000C, 32'h0, 1'b1, 8'h22, 32'h0,  1'b0, 1'b0};

    // Reset, then 5 idle edges: cycle counter reads 5.
    tick(); tick();
    check("reset rdata", resp_rdata, 32'h0);
    check("reset hit", {31'd0, resp_hit}, 32'h0);
    check("reset tx_valid", {31'd0, tx_valid}, 32'h0);
    rst = 1'b1;
    repeat (5) tick();
    load(A_CYC);
    check("cycle after 5", resp_rdata, 32'd5);
    check("cycle hit", {31'd0, resp_hit}, 32'h1);
    load(A_CTRL);
    check("ctrl idle", resp_rdata, 32'h1);
    tick();
    check("hit idle", {31'd0, resp_hit}, 32'h0);
    check("rdata hold", resp_rdata, 32'h1);

    // Counters: retire 3 of 10, then clear with a coincident retire.
    store(A_CRST, 32'hDEAD);
    for (int i = 0; i < 10; i++) begin
      inst_retire = (i == 1 || i == 4 || i == 7);
      tick();
    end
    inst_retire = 1'b0;
    load(A_INSTR);
    check("instr 3", resp_rdata, 32'd3);
    load(A_CYC);
    check("cycle 11", resp_rdata, 32'd11);
    inst_retire = 1'b1;
    store(A_CRST, 32'h0);
    inst_retire = 1'b0;
    load(A_INSTR);
    check("instr cleared", resp_rdata, 32'd0);
    load(A_CYC);
    check("cycle cleared", resp_rdata, 32'd1);

    // Table: decode, RX pop, unmapped and write-only addresses.
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1;
      req_we    = vecs[i].we;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wdata;
      rx_valid  = vecs[i].rxv;
      rx_data   = vecs[i].rxd;
      #1;
      check($sformatf("vec%0d rx_ready", i), {31'd0, rx_ready}, {31'd0, vecs[i].exp_rx_ready});
      tick();
      check($sformatf("vec%0d rdata", i), resp_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d hit", i), {31'd0, resp_hit}, {31'd0, vecs[i].exp_hit});
    end
    idle();
    rx_valid = 1'b1;
    #1;
    check("rx_ready no req", {31'd0, rx_ready}, 32'h0);
    rx_valid = 1'b0;

    // Overfill TX by one byte while the UART is stalled.
    tx_ready = 1'b0;
    for (int i = 1; i <= TX_CAP + 1; i++) store(A_TX, 32'hFFFF_FF00 | i);
    load(A_CTRL);
    check("ctrl full+ovf", resp_rdata, 32'h4);
    load(A_CTRL);
    check("ctrl ovf cleared", resp_rdata, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < TX_CAP; i++) begin
      check($sformatf("drain%0d valid", i), {31'd0, tx_valid}, 32'h1);
      check($sformatf("drain%0d data", i), {24'd0, tx_data}, 32'(i + 1));
      tick();
    end
    check("drain empty", {31'd0, tx_valid}, 32'h0);

    // Store into a full TX path while it dequeues: dropped, overflow set.
    tx_ready = 1'b0;
    for (int i = 0; i < TX_CAP; i++) store(A_TX, 32'h10 + i);
    tx_ready = 1'b1;
    store(A_TX, 32'h77);
    tx_ready = 1'b0;
    load(A_CTRL);
    check("ctrl ovf+space", resp_rdata, 32'h5);
    tx_ready = 1'b1;
    n = 0;
    for (int i = 0; i < TX_CAP + 2 && tx_valid; i++) begin
      check($sformatf("same-cycle drain%0d", i), {24'd0, tx_data}, 32'h11 + i);
      n++;
      tick();
    end
    check("same-cycle count", n, TX_CAP - 1);
    check("same-cycle empty", {31'd0, tx_valid}, 32'h0);

    // Counter wrap at 2^32.
    force dut.r_cyc_cnt = 32'hFFFF_FFFF;
    force dut.r_instr_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_cyc_cnt;
    release dut.r_instr_cnt;
    inst_retire = 1'b1;
    load(A_CYC);
    inst_retire = 1'b0;
    check("cycle max", resp_rdata, 32'hFFFF_FFFF);
    load(A_INSTR);
    check("instr wrapped", resp_rdata, 32'h0);
    load(A_CYC);
    check("cycle wrapped", resp_rdata, 32'h1);

    // Reset in the middle of a TX drain.
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(A_TX, 32'hA1 + i);
    tx_ready = 1'b1;
    tick();
    check("pre-reset valid", {31'd0, tx_valid}, (TX_CAP > 1) ? 32'h1 : 32'h0);
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_RX;
    rx_valid = 1'b1; rx_data = 8'h55;
    #1;
    check("rx_ready in reset", {31'd0, rx_ready}, 32'h0);
    tick();
    check("reset tx_valid mid", {31'd0, tx_valid}, 32'h0);
    check("reset hit mid", {31'd0, resp_hit}, 32'h0);
    check("reset rdata mid", resp_rdata, 32'h0);
    rst = 1'b1;
    idle();
    rx_valid = 1'b0;
    tick();
    check("post-reset empty", {31'd0, tx_valid}, 32'h0);
    load(A_CTRL);
    check("post-reset ctrl", resp_rdata, 32'h1);
    load(A_CYC);
    check("post-reset cycle", resp_rdata, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmio_io_responder.md
Name: mmio_io_responder

Overview:
Responder side of the core's memory-mapped IO port for the 0x8000_00xx region. It decodes load/store requests issued by the pipeline and returns registered read data one cycle later, matching the data-memory read latency. It owns the cycle and instruction counters and a TX byte FIFO feeding the on-chip UART transmitter. It also pops received bytes from the UART receiver.

Parameters:
TX_FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2 (ignored without MMIO_TX_FIFO_EN).
MMIO_BASE, 32'h8000_0000, base address of the register window.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous, active-low reset (0 = reset).
req_valid  in  1  MMIO request this cycle; the core already gates it with stall.
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data; only bits [7:0] are used.
inst_retire  in  1  one instruction retired this cycle.
resp_rdata  out  32  load data, valid the cycle after the request.
resp_hit  out  1  registered; 1 if the previous-cycle load hit a mapped read register.
tx_data  out  8  byte to UART transmitter.
tx_valid  out  1  FIFO non-empty.
tx_ready  in  1  UART accepts byte.
rx_data  in  8  byte from UART receiver.
rx_valid  in  1  receiver holds a byte.
rx_ready  out  1  pop receiver; combinational.

Behaviour:
- Register map (offsets from MMIO_BASE):
  - 0x00 R  ctrl = {29'd0, tx_overflow, rx_valid, tx_space}; tx_space = FIFO not full.
  - 0x04 R  rx data.
  - 0x08 W  tx data.
  - 0x10 R  cycle counter.
  - 0x14 R  instruction counter.
  - 0x18 W  counter reset; data ignored.
- Decode compares the full 32-bit address. A request at any other address returns rdata 0, resp_hit 0, and writes have no effect.
- Read timing: load at edge N is captured and presented on resp_rdata/resp_hit after edge N. resp_rdata holds its value until the next load; resp_hit is 0 on non-load cycles.
- RX pop: rx_ready = req_valid & !req_we & (addr == 0x04) & rx_valid.
  - The byte is captured as {24'd0, rx_data} on the same edge the pop occurs.
  - A read of 0x04 with rx_valid = 0 returns 0 and does not pop.
- TX write to 0x08:
  - FIFO not full: enqueue req_wdata[7:0].
  - FIFO full: drop the byte and set sticky tx_overflow.
  - The full check uses the pre-edge count, so a same-cycle dequeue does not make room.
- ctrl read captures the current tx_overflow value and clears it at the same edge. If an overflow occurs on that same cycle, the set wins.
- TX drain: tx_data = FIFO head; dequeue on tx_valid & tx_ready. A simultaneous enqueue and dequeue keeps the count unchanged.
- cycle_counter: +1 every cycle; wraps at 2^32.
- instr_counter: +1 when inst_retire = 1; wraps at 2^32.
- Store to 0x18 makes both counters read 0 in the next cycle. The reset wins over a same-cycle increment or retire.
- Reset (rst = 0), applied at any time including mid-transfer:
  - counters 0, FIFO empty, tx_overflow 0.
  - resp_rdata 0, resp_hit 0, tx_valid 0.
  - rx_ready is 0 while in reset; requests during reset are ignored.

Optional Feature:
MMIO_TX_FIFO_EN:
- Defined: TX path is a TX_FIFO_DEPTH-entry circular FIFO.
- Undefined: TX path is a single holding register.
  - tx_space = !tx_valid.
  - A write while full is dropped and sets tx_overflow.
  - Dequeue and enqueue in the same cycle behave as for the FIFO (write dropped).

Decomposition:
- Shared package (mmio_pkg): MMIO_BASE and the six offset localparams, ctrl bit-index constants, counter width (32).
- Sub-module mmio_tx_fifo (params WIDTH = 8, DEPTH): ptr/count logic, full/empty. It is instantiated only under MMIO_TX_FIFO_EN.

Test Plan:
1. Reset, then idle 5 cycles; read 0x10 -> resp_rdata = 5 or 6 per edge count (bench computes exactly); read 0x00 -> 32'h1 (tx_space, no rx, no overflow).
2. Pulse inst_retire on 3 of 10 cycles, read 0x14 -> 3. Store 0x18 in the same cycle as inst_retire = 1, then read 0x14 -> 0; next read 0x10 -> small value counting from 0.
3. rx_valid = 1, rx_data = 8'hA5; load 0x04 -> rx_ready high that cycle only, resp_rdata = 32'h0000_00A5 next cycle. Load 0x04 with rx_valid = 0 -> rdata 0, rx_ready 0.
4. tx_ready = 0; store 9 bytes 0x01..0x09 with depth 8:
   - ctrl bit0 = 0 and bit2 = 1.
   - Second ctrl read shows bit2 = 0.
   - Raise tx_ready -> bytes 0x01..0x08 emitted in order; 0x09 is lost.
5. FIFO full with tx_ready = 1; store in the same cycle as a dequeue -> byte dropped, overflow set, count becomes 7.
6. Counters 0xFFFF_FFFF (forced via long run or force) -> wrap to 0. Assert rst = 0 mid-TX drain -> tx_valid = 0 next cycle and the FIFO is empty after release.
